// File: rtl/nested_loop_ctrl.sv
// Sequencer for a three-deep i/j/k loop nest over external counter registers.
// It clears and steps the counters and handshakes one body execution per (i,j,k).
module nested_loop_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic             start,
    input  logic             step_ack,
    input  logic             z_i,
    input  logic             z_j,
    input  logic             z_k,
    output logic             rst_i,
    output logic             rst_j,
    output logic             rst_k,
    output logic             inc_i,
    output logic             inc_j,
    output logic             inc_k,
    output logic             step_req,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step_cnt
);

    typedef enum logic [3:0] {
        IDLE, CLR, CHK0, BODY, INCK, CHKK,
        INCJ, CHKJ, INCI, CHKI, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic rst_i_q, rst_j_q, rst_k_q;
    logic rst_i_d, rst_j_d, rst_k_d;
    logic inc_i_q, inc_j_q, inc_k_q;
    logic inc_i_d, inc_j_d, inc_k_d;
    logic req_q, busy_q, done_q;
    logic req_d, busy_d, done_d;

    // z flags are only trusted in CHK* states, one cycle after a strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = CLR;
                cnt_d   = '0;
            end
            CLR:  state_d = CHK0;
            CHK0: state_d = (z_i | z_j | z_k) ? DONE : BODY;
            BODY: if (step_ack) begin
                state_d = INCK;
                cnt_d   = cnt_q + 1'b1;
            end
            INCK: state_d = CHKK;
            CHKK: state_d = z_k ? INCJ : BODY;
            INCJ: state_d = CHKJ;
            CHKJ: state_d = z_j ? INCI : BODY;
            INCI: state_d = CHKI;
            CHKI: state_d = z_i ? DONE : BODY;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the next state so they are registered with it
    always_comb begin
        rst_i_d = (state_d == CLR);
        rst_j_d = (state_d == CLR) || (state_d == INCI);
        rst_k_d = (state_d == CLR) || (state_d == INCJ);
        inc_i_d = (state_d == INCI);
        inc_j_d = (state_d == INCJ);
        inc_k_d = (state_d == INCK);
        req_d   = (state_d == BODY);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rst_i_q <= 1'b0;
            rst_j_q <= 1'b0;
            rst_k_q <= 1'b0;
            inc_i_q <= 1'b0;
            inc_j_q <= 1'b0;
            inc_k_q <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_i_q <= rst_i_d;
            rst_j_q <= rst_j_d;
            rst_k_q <= rst_k_d;
            inc_i_q <= inc_i_d;
            inc_j_q <= inc_j_d;
            inc_k_q <= inc_k_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rst_i    = rst_i_q;
    assign rst_j    = rst_j_q;
    assign rst_k    = rst_k_q;
    assign inc_i    = inc_i_q;
    assign inc_j    = inc_j_q;
    assign inc_k    = inc_k_q;
    assign step_req = req_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_nested_loop_ctrl.sv
// Scoreboard bench for nested_loop_ctrl with modelled i/j/k counter registers.
// Expected (i,j,k) handshakes and final counts are queued; a monitor pops them.
module tb_nested_loop_ctrl;

    logic        Clk = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        step_ack = 1'b0;
    logic        z_i, z_j, z_k;
    logic        rst_i, rst_j, rst_k;
    logic        inc_i, inc_j, inc_k;
    logic        step_req, busy, done;
    logic [15:0] step_cnt;

    logic [7:0] ci = 8'd0, cj = 8'd0, ck = 8'd0;
    logic [7:0] lim_i = 8'd0, lim_j = 8'd0, lim_k = 8'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hold = 1;
    int age = 0;
    int req_len = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int n_inc_i = 0, n_inc_j = 0, n_inc_k = 0;
    bit prev_done = 1'b0;

    int exp_hs[$];
    int exp_done[$];

    nested_loop_ctrl #(.CNT_W(16)) dut (
        .Clk      (Clk),
        .RST      (RST),
        .start    (start),
        .step_ack (step_ack),
        .z_i      (z_i),
        .z_j      (z_j),
        .z_k      (z_k),
        .rst_i    (rst_i),
        .rst_j    (rst_j),
        .rst_k    (rst_k),
        .inc_i    (inc_i),
        .inc_j    (inc_j),
        .inc_k    (inc_k),
        .step_req (step_req),
        .busy     (busy),
        .done     (done),
        .step_cnt (step_cnt)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // External counter registers: strobe in cycle n, new value in n+1
    always @(posedge Clk) begin
        if (rst_i) ci <= 8'd0; else if (inc_i) ci <= ci + 8'd1;
        if (rst_j) cj <= 8'd0; else if (inc_j) cj <= cj + 8'd1;
        if (rst_k) ck <= 8'd0; else if (inc_k) ck <= ck + 8'd1;
    end

    assign z_i = (lim_i <= ci);
    assign z_j = (lim_j <= cj);
    assign z_k = (lim_k <= ck);

    // Datapath: acknowledge in the hold-th cycle of each request
    always begin
        @(posedge Clk);
        #2;
        if (step_req) begin
            step_ack = (age == hold - 1);
            age++;
        end else begin
            step_ack = 1'b0;
            age = 0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor
    always @(negedge Clk) begin
        int e;
        bit bad;
        if (step_req) req_len++;
        if (step_req && step_ack) begin
            hs_cnt++;
            if (exp_hs.size() == 0) chk("hs_extra", 1, 0);
            else begin
                e = exp_hs.pop_front();
                chk("hs_ijk", int'({ci, cj, ck}), e);
            end
            chk("req_len", req_len, hold);
            req_len = 0;
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (exp_done.size() == 0) chk("done_extra", 1, 0);
            else chk("done_step_cnt", int'(step_cnt), exp_done.pop_front());
            chk("done_busy", int'(busy), 1);
        end
        if (prev_done) chk("busy_after_done", int'(busy), 0);
        prev_done = done;
        bad = (int'(inc_i) + int'(inc_j) + int'(inc_k) > 1)
            || ((step_req || done || !busy)
                && (rst_i || rst_j || rst_k || inc_i || inc_j || inc_k))
            || (inc_j && !rst_k) || (inc_i && !rst_j)
            || (step_req && done);
        chk("strobe_rules", int'(bad), 0);
        if (inc_i) n_inc_i++;
        if (inc_j) n_inc_j++;
        if (inc_k) n_inc_k++;
    end

    task automatic launch(input int li, input int lj, input int lk,
                          input int h, output int st);
        lim_i = 8'(li);
        lim_j = 8'(lj);
        lim_k = 8'(lk);
        hold = h;
        n_inc_i = 0;
        n_inc_j = 0;
        n_inc_k = 0;
        for (int i = 0; i < li; i++)
            for (int j = 0; j < lj; j++)
                for (int k = 0; k < lk; k++)
                    exp_hs.push_back((i << 16) | (j << 8) | k);
        exp_done.push_back(li * lj * lk);
        start = 1'b1;
        st = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run(input int li, input int lj, input int lk,
                       input int h, input bit repulse, input int lat);
        int st;
        int base;
        int n;
        bit got, pb, pj;
        n = li * lj * lk;
        base = done_cnt;
        got = 1'b0;
        pb = 1'b0;
        pj = 1'b0;
        launch(li, lj, lk, h, st);
        for (int c = 0; c < 2000 && !got; c++) begin
            if (done_cnt > base) got = 1'b1;
            else begin
                if (repulse) begin
                    if (start) start = 1'b0;
                    else if (step_req && !pb) begin
                        start = 1'b1;
                        pb = 1'b1;
                    end else if (inc_j && !pj) begin
                        start = 1'b1;
                        pj = 1'b1;
                    end
                end
                tick();
            end
        end
        start = 1'b0;
        chk("done_timeout", int'(got), 1);
        if (lat >= 0) chk("done_latency", last_done_cyc - st, lat);
        if (repulse) chk("repulse_issued", int'(pb && pj), 1);
        repeat (4) tick();
        chk("done_once", done_cnt - base, 1);
        chk("idle_busy", int'(busy), 0);
        chk("step_cnt_hold", int'(step_cnt), n);
        chk("n_inc_k", n_inc_k, n);
        chk("n_inc_j", n_inc_j, (lk == 0) ? 0 : li * lj);
        chk("n_inc_i", n_inc_i, (lk == 0 || lj == 0) ? 0 : li);
        chk("hs_queue_empty", exp_hs.size(), 0);
    endtask

    initial begin
        int st;
        int base;
        bit hit;

        RST = 1'b1;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_step_req", int'(step_req), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_strobes",
            int'({rst_i, rst_j, rst_k, inc_i, inc_j, inc_k}), 0);
        chk("rst_step_cnt", int'(step_cnt), 0);
        RST = 1'b0;
        tick();

        run(2, 2, 2, 1, 1'b0, -1);
        run(0, 3, 3, 1, 1'b0, 3);
        run(1, 1, 3, 4, 1'b0, -1);

        // Reset during the 5th body of a 2/2/2 run
        base = hs_cnt;
        launch(2, 2, 2, 1, st);
        hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            if (step_req && (hs_cnt - base == 4)) hit = 1'b1;
            else tick();
        end
        chk("abort_reached", int'(hit), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_step_req", int'(step_req), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_strobes",
            int'({rst_i, rst_j, rst_k, inc_i, inc_j, inc_k}), 0);
        chk("abort_step_cnt", int'(step_cnt), 0);
        exp_hs.delete();
        exp_done.delete();
        base = hs_cnt;
        repeat (6) tick();
        chk("no_resume_busy", int'(busy), 0);
        chk("no_resume_hs", hs_cnt - base, 0);

        run(2, 2, 2, 1, 1'b0, -1);
        run(1, 2, 2, 1, 1'b1, -1);
        run(3, 1, 1, 1, 1'b0, -1);

        chk("final_hs_queue", exp_hs.size(), 0);
        chk("final_done_queue", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nested_loop_ctrl.md
NESTED_LOOP_CTRL -- requirements
Module: nested_loop_ctrl

Interface
REQ-001 Parameter SHALL be CNT_W, default 16, width of the step_cnt iteration counter.
REQ-002 Clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  single-cycle request to run the loop nest; SHALL be ignored unless in IDLE.
REQ-005 step_ack  input  1  body-done acknowledge from the datapath for the current iteration.
REQ-006 z_i, z_j, z_k  input  1 each  flags from the external i/j/k counter registers; 1 = limit <= count (loop exhausted).
REQ-007 rst_i, rst_j, rst_k  output  1 each  clear strobes to the counter registers.
REQ-008 inc_i, inc_j, inc_k  output  1 each  increment strobes to the counter registers.
REQ-009 step_req  output  1  body-execute request for the current (i,j,k).
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 step_cnt  output  CNT_W  number of acknowledged iterations since the last accepted start.

Function
REQ-013 States SHALL be IDLE, CLR, CHK0, BODY, INCK, CHKK, INCJ, CHKJ, INCI, CHKI, DONE.
REQ-014 All outputs SHALL be registered or decoded from state only, with no combinational path from any input.
REQ-015 External counter timing: a strobe in cycle n updates the counter at the edge ending cycle n, so its z flag is valid in cycle n+1; the controller SHALL sample z only in CHK* states.
REQ-016 IDLE: if start=1, go to CLR and clear step_cnt to 0.
REQ-017 CLR: assert rst_i, rst_j, rst_k for exactly one cycle, then go to CHK0.
REQ-018 CHK0: if z_i|z_j|z_k, go to DONE (zero iterations); else go to BODY.
REQ-019 BODY: hold step_req=1 until step_ack=1 is sampled; on that edge increment step_cnt and go to INCK. step_ack outside BODY SHALL be ignored.
REQ-020 INCK: assert inc_k for one cycle, then go to CHKK.
REQ-021 CHKK: if z_k=0, go to BODY; else go to INCJ.
REQ-022 INCJ: assert rst_k and inc_j in the same cycle, then go to CHKJ.
REQ-023 CHKJ: if z_j=0, go to BODY; else go to INCI.
REQ-024 INCI: assert rst_j and inc_i in the same cycle, then go to CHKI.
REQ-025 CHKI: if z_i=0, go to BODY; else go to DONE.
REQ-026 DONE: assert done for one cycle, then go to IDLE; counter registers SHALL be left at their final values.
REQ-027 With nonzero limits Li, Lj, Lk, the controller SHALL issue exactly Li*Lj*Lk step_req handshakes, in k-fastest order.
REQ-028 step_cnt SHALL wrap modulo 2^CNT_W and SHALL hold its value in IDLE until the next accepted start.
REQ-029 No strobe SHALL assert in IDLE, BODY, CHK0, CHKK, CHKJ, CHKI or DONE.
REQ-030 No more than one inc_* SHALL assert per cycle.
REQ-031 start asserted while busy=1 SHALL have no effect.

Reset
REQ-032 When RST=1 at an edge, the next state SHALL be IDLE, with step_cnt=0 and every output low; RST SHALL override all other inputs, including mid-loop.
REQ-033 After reset release, the block SHALL require a new start; an interrupted loop SHALL NOT resume.

Verification
REQ-034 Bench models three 8-bit counter registers (z = limit <= count). Limits 2/2/2, step_ack same cycle as step_req -> 8 handshakes, (i,j,k) sequence 000..111, done pulses once, step_cnt=8, busy falls the cycle after done.
REQ-035 Limits 0/3/3, start -> CLR, CHK0, DONE; zero step_req, step_cnt=0, done 3 cycles after start is accepted.
REQ-036 Limits 1/1/3, step_ack delayed 4 cycles each -> step_req held high 4 cycles per iteration, 3 handshakes, step_cnt=3.
REQ-037 RST pulsed during the 5th BODY of a 2/2/2 run -> IDLE the next cycle, all outputs 0, step_cnt=0; a new start runs 8 fresh iterations.
REQ-038 start re-pulsed during BODY and during INCJ of a 1/2/2 run -> ignored; exactly 4 handshakes and one done.
REQ-039 Limits 3/1/1 -> each CHKK and CHKJ sees z=1; rst_k+inc_j and rst_j+inc_i pairs coincide as specified; 3 handshakes.
